// File: rtl/pin_entry_ctrl.sv
// Keypad PIN entry: 3-digit code with backspace/clear/enter, retry count, open and lockout timers.
// Outputs react two clocks after a key goes one-hot; optional PIN change under `PIN_CHANGE_EN.
module pin_entry_ctrl #(
    parameter logic [11:0] PWD         = 12'h123,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned OPEN_CYCLES = 150_000_000,
    parameter int unsigned LOCK_CYCLES = 500_000_000
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic [15:0] key_deb,
    output logic [11:0] data,
    output logic [2:0]  tries,
    output logic        unlocked,
    output logic        locked,
    output logic        err_pulse
);

    localparam logic [11:0] BLANK    = 12'hFFF;
    localparam logic [11:0] DASHES   = 12'hAAA;
    localparam logic [2:0]  MAX_T    = 3'(MAX_TRIES);
    localparam logic [31:0] OPEN_LD  = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0] LOCK_LD  = 32'(LOCK_CYCLES - 1);

`ifdef PIN_CHANGE_EN
    typedef enum logic [2:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_LOCKOUT, ST_NEWPIN} state_t;
`else
    typedef enum logic [2:0] {ST_ENTRY, ST_CHECK, ST_OPEN, ST_LOCKOUT} state_t;
`endif

    state_t      state_q, state_d;
    logic [15:0] prev_q;
    logic        evt_q, evt_d;
    logic [3:0]  key_q, key_idx;
    logic        onehot;
    logic [11:0] data_q, data_d, edit_data, pin_val;
    logic [1:0]  cnt_q, cnt_d, edit_cnt;
    logic [2:0]  tries_q, tries_d;
    logic [31:0] timer_q, timer_d;
    logic        err_q, err_d;
    logic        is_digit, is_back, is_enter, is_clear;

`ifdef PIN_CHANGE_EN
    logic [11:0] pin_q, pin_d;
    logic        is_newpin;
    assign pin_val   = pin_q;
    assign is_newpin = evt_q && (key_q == 4'd13);
`else
    assign pin_val   = PWD;
`endif

    // A press counts only on a clean 0 -> one-hot transition.
    always_comb begin
        onehot  = (key_deb != 16'd0) && ((key_deb & (key_deb - 16'd1)) == 16'd0);
        key_idx = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (key_deb[k]) key_idx = 4'(k);
        end
        evt_d = onehot && (prev_q == 16'd0);
    end

    assign is_digit = evt_q && (key_q <= 4'd9);
    assign is_back  = evt_q && (key_q == 4'd10);
    assign is_enter = evt_q && (key_q == 4'd11);
    assign is_clear = evt_q && (key_q == 4'd12);

    always_comb begin
        edit_data = data_q;
        edit_cnt  = cnt_q;
        if (is_digit && cnt_q != 2'd3) begin
            edit_data = {data_q[7:0], key_q};
            edit_cnt  = cnt_q + 2'd1;
        end else if (is_back && cnt_q != 2'd0) begin
            edit_data = {4'hF, data_q[11:4]};
            edit_cnt  = cnt_q - 2'd1;
        end else if (is_clear) begin
            edit_data = BLANK;
            edit_cnt  = 2'd0;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        tries_d = tries_q;
        timer_d = timer_q;
        err_d   = 1'b0;
`ifdef PIN_CHANGE_EN
        pin_d   = pin_q;
`endif
        case (state_q)
            ST_ENTRY: begin
                data_d = edit_data;
                cnt_d  = edit_cnt;
                if (is_enter && cnt_q == 2'd3) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                data_d = BLANK;
                cnt_d  = 2'd0;
                if (data_q == pin_val) begin
                    tries_d = MAX_T;
                    timer_d = OPEN_LD;
                    state_d = ST_OPEN;
                end else begin
                    err_d   = 1'b1;
                    tries_d = (tries_q != 3'd0) ? tries_q - 3'd1 : 3'd0;
                    if (tries_q <= 3'd1) begin
                        timer_d = LOCK_LD;
                        state_d = ST_LOCKOUT;
                    end else begin
                        state_d = ST_ENTRY;
                    end
                end
            end
            ST_OPEN: begin
                // Timer expiry wins over any key arriving in the same cycle.
                if (timer_q == 32'd0 || is_clear) begin
                    timer_d = 32'd0;
                    state_d = ST_ENTRY;
                end else begin
                    timer_d = timer_q - 32'd1;
`ifdef PIN_CHANGE_EN
                    if (is_newpin) state_d = ST_NEWPIN;
`endif
                end
            end
            ST_LOCKOUT: begin
                if (timer_q == 32'd0) begin
                    tries_d = MAX_T;
                    data_d  = BLANK;
                    cnt_d   = 2'd0;
                    state_d = ST_ENTRY;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
`ifdef PIN_CHANGE_EN
            ST_NEWPIN: begin
                data_d = edit_data;
                cnt_d  = edit_cnt;
                if (is_clear) begin
                    state_d = ST_ENTRY;
                end else if (is_enter && cnt_q == 2'd3) begin
                    pin_d   = data_q;
                    data_d  = BLANK;
                    cnt_d   = 2'd0;
                    state_d = ST_ENTRY;
                end
            end
`endif
            default: state_d = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= ST_ENTRY;
            prev_q  <= 16'd0;
            evt_q   <= 1'b0;
            key_q   <= 4'd0;
            data_q  <= BLANK;
            cnt_q   <= 2'd0;
            tries_q <= MAX_T;
            timer_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef PIN_CHANGE_EN
            pin_q   <= PWD;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= key_deb;
            evt_q   <= evt_d;
            key_q   <= key_idx;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            tries_q <= tries_d;
            timer_q <= timer_d;
            err_q   <= err_d;
`ifdef PIN_CHANGE_EN
            pin_q   <= pin_d;
`endif
        end
    end

    assign data      = (state_q == ST_LOCKOUT) ? DASHES : data_q;
    assign tries     = tries_q;
`ifdef PIN_CHANGE_EN
    assign unlocked  = (state_q == ST_OPEN) || (state_q == ST_NEWPIN);
`else
    assign unlocked  = (state_q == ST_OPEN);
`endif
    assign locked    = (state_q == ST_LOCKOUT);
    assign err_pulse = err_q;

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// Bench for pin_entry_ctrl: a digit-list reference model predicts every output change and its cycle;
// a negedge monitor compares each observed change against the predicted queue.
module tb_pin_entry_ctrl;
    localparam int          OPEN_C = 20;
    localparam int          LOCK_C = 50;
    localparam int          MAXT   = 3;
    localparam logic [11:0] PWD    = 12'h123;

    localparam int S_ENTRY = 0, S_OPEN = 1, S_LOCK = 2, S_NEWPIN = 3;

    logic        clk = 1'b0;
    logic        RSTn = 1'b1;
    logic [15:0] key_deb = 16'd0;
    logic [11:0] data;
    logic [2:0]  tries;
    logic        unlocked, locked, err_pulse;

    pin_entry_ctrl #(.PWD(PWD), .MAX_TRIES(MAXT), .OPEN_CYCLES(OPEN_C), .LOCK_CYCLES(LOCK_C)) dut (
        .clk(clk), .RSTn(RSTn), .key_deb(key_deb), .data(data), .tries(tries),
        .unlocked(unlocked), .locked(locked), .err_pulse(err_pulse));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [11:0] data;
        logic [2:0]  tries;
        logic        unl;
        logic        lck;
        logic        err;
    } snap_t;
    typedef struct {
        snap_t s;
        int    cyc;
    } exp_t;

    exp_t  expq[$];
    int    checks = 0, failures = 0;
    bit    mon_en = 1'b0;
    snap_t last_obs;

    int          m_st, m_tries, m_deadline;
    int          m_dig[$];
    logic [11:0] m_pin;
    logic        m_err;
    snap_t       m_last;

    function automatic snap_t reset_snap();
        snap_t s;
        s = {12'hFFF, 3'(MAXT), 1'b0, 1'b0, 1'b0};
        return s;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.data = 12'hFFF;
        if (m_st == S_LOCK) s.data = 12'hAAA;
        else foreach (m_dig[i]) s.data = {s.data[7:0], 4'(m_dig[i])};
        s.tries = 3'(m_tries);
        s.unl   = (m_st == S_OPEN) || (m_st == S_NEWPIN);
        s.lck   = (m_st == S_LOCK);
        s.err   = m_err;
        return s;
    endfunction

    task automatic emit(int c);
        snap_t s;
        s = model_snap();
        if (s !== m_last) begin
            expq.push_back('{s, c});
            m_last = s;
        end
    endtask

    task automatic model_reset();
        m_st = S_ENTRY; m_tries = MAXT; m_deadline = 0;
        m_dig.delete(); m_pin = PWD; m_err = 1'b0; m_last = reset_snap();
    endtask

    // Apply a timer expiry whose exit edge is at or before 'upto'.
    task automatic model_flush(int upto);
        if ((m_st == S_OPEN || m_st == S_LOCK) && m_deadline <= upto) begin
            if (m_st == S_LOCK) m_tries = MAXT;
            m_st = S_ENTRY;
            m_dig.delete();
            emit(m_deadline);
        end
    endtask

    task automatic do_check(int p);
        logic [11:0] entered;
        entered = {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2])};
        m_dig.delete();
        if (entered == m_pin) begin
            m_tries = MAXT; m_st = S_OPEN; m_deadline = p + 1 + OPEN_C;
            emit(p + 1);
        end else begin
            m_tries = m_tries - 1; m_err = 1'b1;
            if (m_tries == 0) begin
                m_st = S_LOCK; m_deadline = p + 1 + LOCK_C;
            end
            emit(p + 1);
            m_err = 1'b0;
            emit(p + 2);
        end
    endtask

    // Key k takes effect at the clock edge numbered p.
    task automatic model_key(int k, int p);
        model_flush(p - 1);
        if ((m_st == S_OPEN || m_st == S_LOCK) && m_deadline == p) begin
            model_flush(p);
            return;
        end
        case (m_st)
            S_ENTRY, S_NEWPIN: begin
                if (k <= 9) begin
                    if (m_dig.size() < 3) m_dig.push_back(k);
                end else if (k == 10) begin
                    if (m_dig.size() > 0) void'(m_dig.pop_back());
                end else if (k == 12) begin
                    m_dig.delete();
                    m_st = S_ENTRY;
                end else if (k == 11 && m_dig.size() == 3) begin
                    if (m_st == S_NEWPIN) begin
                        m_pin = {4'(m_dig[0]), 4'(m_dig[1]), 4'(m_dig[2])};
                        m_dig.delete();
                        m_st = S_ENTRY;
                    end else begin
                        do_check(p);
                        return;
                    end
                end
                emit(p);
            end
            S_OPEN: begin
                if (k == 12) begin
                    m_st = S_ENTRY;
                    emit(p);
                end
`ifdef PIN_CHANGE_EN
                else if (k == 13) m_st = S_NEWPIN;
`endif
            end
            default: ;
        endcase
    endtask

    function automatic bit onehot16(logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    function automatic int idx16(logic [15:0] v);
        int r = 0;
        for (int i = 0; i < 16; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
        model_flush(cyc + 1);
    endtask

    task automatic drive(logic [15:0] v);
        if (key_deb == 16'd0 && onehot16(v)) model_key(idx16(v), cyc + 2);
        key_deb = v;
    endtask

    task automatic press(logic [15:0] v, int hold, int rel);
        drive(v);
        repeat (hold) tick();
        drive(16'd0);
        repeat (rel) tick();
    endtask

    task automatic key(int k);
        logic [15:0] v;
        v = 16'd1 << k;
        press(v, 1, 2);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        key_deb = 16'd0;
        #2 RSTn = 1'b0;
        #1;
        chk("rst_data", 32'(data), 32'h0FFF);
        chk("rst_tries", 32'(tries), 32'(MAXT));
        chk("rst_unlocked", 32'(unlocked), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err_pulse", 32'(err_pulse), 32'd0);
        model_reset();
        expq.delete();
        repeat (3) tick();
        RSTn = 1'b1;
        last_obs = reset_snap();
        mon_en = 1'b1;
        tick();
    endtask

    task automatic enter_pin(logic [11:0] pin);
        key(12);
        key(int'(pin[11:8])); key(int'(pin[7:4])); key(int'(pin[3:0]));
        key(11);
    endtask

    always @(negedge clk) begin : monitor
        snap_t cur;
        exp_t  e;
        cur = {data, tries, unlocked, locked, err_pulse};
        if (mon_en && cur !== last_obs) begin
            checks++;
            if (expq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
            end else begin
                e = expq.pop_front();
                if (e.s !== cur || e.cyc != cyc) begin
                    failures++;
                    $display("FAIL out_change got=%h at cyc %0d required=%h at cyc %0d",
                             cur, cyc, e.s, e.cyc);
                end
            end
        end
        if (mon_en) last_obs = cur;
    end

    initial begin
        model_reset();
        do_reset();

        // Correct PIN, then let OPEN expire on its own.
        key(1); key(2); key(3); key(11);
        repeat (OPEN_C + 5) tick();

        // Backspace editing and short enter.
        key(4); key(5); key(10); key(6); key(11);
        key(12);

        // Two-bit vector, long hold, and a second key without release.
        press(16'h0006, 2, 2);
        press(16'h0020, 6, 2);
        drive(16'h0004); tick(); tick();
        drive(16'h0010); tick(); tick();
        drive(16'd0); tick(); tick();
        key(12);

        // Three wrong PINs into lockout; keys in lockout must do nothing.
        repeat (3) begin
            key(9); key(9); key(9); key(11);
        end
        key(1); key(12); key(11); key(10);
        repeat (LOCK_C + 5) tick();

        // Clear while open returns to entry early.
        enter_pin(PWD);
        key(5);
        key(12);
        repeat (3) tick();

`ifdef PIN_CHANGE_EN
        enter_pin(PWD);
        key(13); key(7); key(8); key(9); key(11);
        key(1); key(2); key(3); key(11);
        key(7); key(8); key(9); key(11);
        repeat (OPEN_C + 5) tick();
        enter_pin(12'h789);
        key(13); key(4); key(12);
        enter_pin(12'h789);
        repeat (OPEN_C + 5) tick();
`else
        enter_pin(PWD);
        key(13); key(7); key(8); key(9); key(11);
        repeat (OPEN_C + 5) tick();
`endif

        for (int it = 0; it < 400; it++) begin
            int          r, k;
            logic [15:0] v;
            r = $urandom_range(0, 99);
            if (r < 12) begin
                enter_pin(m_pin);
            end else if (r < 18) begin
                v = 16'($urandom);
                press(v, $urandom_range(1, 3), $urandom_range(1, 4));
            end else if (r < 23) begin
                repeat ($urandom_range(0, 30)) tick();
            end else begin
                k = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
                v = 16'd1 << k;
                press(v, $urandom_range(1, 3), $urandom_range(1, 4));
            end
        end
        repeat (LOCK_C + 10) tick();

        // Reset asserted in the middle of a lockout.
        do_reset();
        repeat (3) begin
            key(9); key(9); key(9); key(11);
        end
        repeat (10) tick();
        chk("locked_before_reset", 32'(locked), 32'd1);
        do_reset();
        key(1); key(2); key(3); key(11);
        repeat (OPEN_C + 5) tick();

        chk("pending_expectations", 32'(expq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
